// File: rtl/rx_link_pkg.sv
// Shared types and constants for the RX link monitor: link state encoding,
// the K28.5 comma code and the LED blink counter width.
package rx_link_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } link_state_t;

    localparam logic [7:0] K28_5   = 8'hBC;
    localparam int         BLINK_W = 26;

endpackage

// File: rtl/rx_byte_checker.sv
// Classifies each decoded RX byte as comma / error and tracks the expected
// incrementing data value.
module rx_byte_checker
    import rx_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_k,
    input  logic       rx_cv_err,
    input  logic       rx_disp_err,
    input  logic       clear_seed,
    output logic       comma,
    output logic       err
);

    logic [7:0] expected;
    logic       seed_valid;
    logic       data;

    always_comb begin
        comma = rx_k && (rx_data == K28_5);
        data  = !rx_k;
        err   = rx_cv_err || rx_disp_err || (rx_k && (rx_data != K28_5)) ||
                (data && seed_valid && (rx_data != expected));
    end

    // The first data byte after a comma only seeds the sequence; later ones are checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected   <= 8'h00;
            seed_valid <= 1'b0;
        end else begin
            if (data) begin
                expected <= rx_data + 8'd1;
            end
            if (clear_seed || comma) begin
                seed_valid <= 1'b0;
            end else if (data) begin
                seed_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_link_monitor.sv
// RX link monitor: HUNT/SYNC/LOCKED lock FSM, windowed loss-of-lock, status LED.
// Optional saturating error counter enabled by macro RX_LINK_MONITOR_ERRCNT_EN.
module rx_link_monitor
    import rx_link_pkg::*;
#(
    parameter int LOCK_COMMAS = 4,
    parameter int ERR_LIMIT   = 8,
    parameter int WINDOW      = 65536,
    parameter int LED_BIT     = 25
) (
    input  logic        rx_clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_k,
    input  logic        rx_cv_err,
    input  logic        rx_disp_err,
    output logic        locked,
    output logic [1:0]  state,
    output logic [15:0] err_count,
    output logic        led
);

    localparam int WIN_W = $clog2(WINDOW);

    link_state_t        state_q, state_d;
    logic [7:0]         comma_cnt_q, comma_cnt_d;
    logic [7:0]         win_err_q, win_err_d, win_err_sum;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               locked_q, led_q;
    logic               comma, err, wrap, go_hunt;

    rx_byte_checker u_checker (
        .clk         (rx_clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_k        (rx_k),
        .rx_cv_err   (rx_cv_err),
        .rx_disp_err (rx_disp_err),
        .clear_seed  (go_hunt),
        .comma       (comma),
        .err         (err)
    );

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        win_err_d   = win_err_q;
        wrap        = (win_cnt_q == WIN_W'(WINDOW - 1));
        // An error on the wrap cycle is the first error of the new window.
        win_err_sum = (wrap ? 8'd0 : win_err_q) + {7'd0, err};
        blink_d     = blink_q + BLINK_W'(1);
        case (state_q)
            HUNT: begin
                if (comma && !err) begin
                    comma_cnt_d = 8'd1;
                    state_d     = (LOCK_COMMAS == 1) ? LOCKED : SYNC;
                end
            end
            SYNC: begin
                if (err) begin
                    state_d = HUNT;
                end else if (comma) begin
                    comma_cnt_d = comma_cnt_q + 8'd1;
                    if (comma_cnt_d == 8'(LOCK_COMMAS)) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                win_err_d = win_err_sum;
                if (win_err_sum >= 8'(ERR_LIMIT)) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
        go_hunt = (state_q != HUNT) && (state_d == HUNT);
        if (go_hunt) begin
            comma_cnt_d = 8'd0;
            win_err_d   = 8'd0;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            comma_cnt_q <= 8'd0;
            win_err_q   <= 8'd0;
            win_cnt_q   <= '0;
            blink_q     <= '0;
            locked_q    <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            win_err_q   <= win_err_d;
            // Window phase starts at zero on the first cycle spent in LOCKED.
            win_cnt_q   <= ((state_q == LOCKED) && (state_d == LOCKED)) ?
                           win_cnt_q + WIN_W'(1) : '0;
            blink_q     <= blink_d;
            locked_q    <= (state_d == LOCKED);
            led_q       <= (state_d == LOCKED) && blink_d[LED_BIT];
        end
    end

`ifdef RX_LINK_MONITOR_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0000;
        end else if (err && (state_q != HUNT) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

    assign state  = state_q;
    assign locked = locked_q;
    assign led    = led_q;

endmodule

// File: tb/tb_rx_link_monitor.sv
// Directed self-checking bench for rx_link_monitor (small-window instance plus
// a saturation instance that stays locked under continuous errors).
module tb_rx_link_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rx_k, rx_cv_err, rx_disp_err;
    logic [7:0]  rx_data;
    logic        locked, led;
    logic [1:0]  state;
    logic [15:0] err_count;

    logic        s_rst_n, s_k, s_cv, s_de;
    logic [7:0]  s_data;
    logic        s_locked, s_led;
    logic [1:0]  s_state;
    logic [15:0] s_err_count;

    int checks = 0;
    int fails  = 0;

`ifdef RX_LINK_MONITOR_ERRCNT_EN
    localparam int SAT_N = 66000;
`else
    localparam int SAT_N = 2000;
`endif

    rx_link_monitor #(.LOCK_COMMAS(4), .ERR_LIMIT(3), .WINDOW(16), .LED_BIT(0)) dut (
        .rx_clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_k(rx_k),
        .rx_cv_err(rx_cv_err), .rx_disp_err(rx_disp_err),
        .locked(locked), .state(state), .err_count(err_count), .led(led)
    );

    rx_link_monitor #(.LOCK_COMMAS(1), .ERR_LIMIT(255), .WINDOW(2), .LED_BIT(25)) dut_sat (
        .rx_clk(clk), .rst_n(s_rst_n), .rx_data(s_data), .rx_k(s_k),
        .rx_cv_err(s_cv), .rx_disp_err(s_de),
        .locked(s_locked), .state(s_state), .err_count(s_err_count), .led(s_led)
    );

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef RX_LINK_MONITOR_ERRCNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic send(input logic [7:0] d, input logic k, input logic cv, input logic de);
        @(negedge clk);
        rx_data = d; rx_k = k; rx_cv_err = cv; rx_disp_err = de;
        @(posedge clk);
        #1;
    endtask

    task automatic s_send(input logic [7:0] d, input logic k, input logic cv);
        @(negedge clk);
        s_data = d; s_k = k; s_cv = cv; s_de = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks += 4;
        if (state !== 2'b00) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
        if (err_count !== 16'h0) begin fails++; $display("FAIL reset_err_count: got %0h want 0", err_count); end
        if (led !== 1'b0) begin fails++; $display("FAIL reset_led: got %b want 0", led); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_stream();
        logic [1:0] exp_st;
        logic       prev_led;
        for (int rep = 0; rep < 4; rep++) begin
            send(8'hBC, 1'b1, 1'b0, 1'b0);
            exp_st = (rep == 3) ? 2'b10 : 2'b01;
            checks += 2;
            if (state !== exp_st) begin fails++; $display("FAIL clean_comma%0d_state: got %0d want %0d", rep, state, exp_st); end
            if (locked !== (rep == 3)) begin fails++; $display("FAIL clean_comma%0d_locked: got %b want %b", rep, locked, rep == 3); end
            prev_led = led;
            for (int d = 0; d < 16; d++) begin
                send(8'(d), 1'b0, 1'b0, 1'b0);
                checks++;
                if (state !== exp_st) begin fails++; $display("FAIL clean_data_state: byte %0h got %0d want %0d", d, state, exp_st); end
                if (rep == 3) begin
                    checks++;
                    if (led !== ~prev_led) begin fails++; $display("FAIL clean_led_blink: got %b want %b", led, ~prev_led); end
                    prev_led = led;
                end
            end
        end
        checks++;
        if (err_count !== 16'h0) begin fails++; $display("FAIL clean_err_count: got %0h want 0", err_count); end
    endtask

    task automatic test_wrap();
        logic [8:0] seq [6];
        seq = '{9'h1BC, 9'h0FE, 9'h0FF, 9'h1BC, 9'h000, 9'h001};
        for (int j = 0; j < 6; j++) begin
            send(seq[j][7:0], seq[j][8], 1'b0, 1'b0);
            checks += 2;
            if (state !== 2'b10) begin fails++; $display("FAIL wrap_state step %0d: got %0d want 2", j, state); end
            if (err_count !== 16'h0) begin fails++; $display("FAIL wrap_err_count step %0d: got %0h want 0", j, err_count); end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (state !== 2'b00) begin fails++; $display("FAIL areset_state: got %0d want 0", state); end
        if (locked !== 1'b0) begin fails++; $display("FAIL areset_locked: got %b want 0", locked); end
        if (err_count !== 16'h0) begin fails++; $display("FAIL areset_err_count: got %0h want 0", err_count); end
        if (led !== 1'b0) begin fails++; $display("FAIL areset_led: got %b want 0", led); end
        @(negedge clk);
        rx_data = 8'h00; rx_k = 1'b0;
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            send(8'hBC, 1'b1, 1'b0, 1'b0);
            checks += 2;
            if (state !== ((c == 4) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL relock_comma%0d_state: got %0d", c, state); end
            if (locked !== (c == 4)) begin fails++; $display("FAIL relock_comma%0d_locked: got %b want %b", c, locked, c == 4); end
        end
    endtask

    task automatic test_loss_of_lock();
        logic [7:0] nxt, d;
        nxt = 8'h10;
        for (int i = 1; i <= 35; i++) begin
            d = (i inside {2, 3, 17, 18, 33, 34, 35}) ? (nxt ^ 8'h80) : nxt;
            send(d, 1'b0, 1'b0, 1'b0);
            nxt = d + 8'd1;
            if (i == 3 || i == 18 || i == 31 || i == 34) begin
                checks++;
                if (state !== 2'b10) begin fails++; $display("FAIL lol_hold_state byte %0d: got %0d want 2", i, state); end
            end
        end
        checks += 4;
        if (state !== 2'b00) begin fails++; $display("FAIL lol_state: got %0d want 0", state); end
        if (locked !== 1'b0) begin fails++; $display("FAIL lol_locked: got %b want 0", locked); end
        if (led !== 1'b0) begin fails++; $display("FAIL lol_led: got %b want 0", led); end
        if (err_count !== exp_cnt(7)) begin fails++; $display("FAIL lol_err_count: got %0d want %0d", err_count, exp_cnt(7)); end
    endtask

    task automatic test_sync_fault();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hBC, 1'b1, 1'b0, 1'b0);
        send(8'hBC, 1'b1, 1'b0, 1'b0);
        send(8'h20, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'b01) begin fails++; $display("FAIL sf_pre_state: got %0d want 1", state); end
        send(8'h21, 1'b0, 1'b0, 1'b1);
        checks += 3;
        if (state !== 2'b00) begin fails++; $display("FAIL sf_state: got %0d want 0", state); end
        if (locked !== 1'b0) begin fails++; $display("FAIL sf_locked: got %b want 0", locked); end
        if (err_count !== exp_cnt(1)) begin fails++; $display("FAIL sf_err_count: got %0d want %0d", err_count, exp_cnt(1)); end
        send(8'h50, 1'b0, 1'b0, 1'b0);
        send(8'hBC, 1'b1, 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b0, 1'b0);
        send(8'h78, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (state !== 2'b01) begin fails++; $display("FAIL sf_reseed_state: got %0d want 1", state); end
        if (err_count !== exp_cnt(1)) begin fails++; $display("FAIL sf_reseed_err_count: got %0d want %0d", err_count, exp_cnt(1)); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        s_rst_n = 1'b1;
        s_send(8'hBC, 1'b1, 1'b0);
        checks += 2;
        if (s_state !== 2'b10) begin fails++; $display("FAIL sat_direct_lock_state: got %0d want 2", s_state); end
        if (s_locked !== 1'b1) begin fails++; $display("FAIL sat_direct_lock_locked: got %b want 1", s_locked); end
        for (int i = 0; i < SAT_N; i++) begin
            s_send(8'h00, 1'b0, 1'b1);
            if (i == 999) begin
                checks++;
                if (s_err_count !== exp_cnt(1000)) begin fails++; $display("FAIL sat_mid_count: got %0d want %0d", s_err_count, exp_cnt(1000)); end
            end
        end
        checks += 3;
        if (s_err_count !== exp_cnt(SAT_N)) begin fails++; $display("FAIL sat_final_count: got %0h want %0h", s_err_count, exp_cnt(SAT_N)); end
        if (s_state !== 2'b10) begin fails++; $display("FAIL sat_state: got %0d want 2", s_state); end
        if (s_led !== 1'b0) begin fails++; $display("FAIL sat_led: got %b want 0", s_led); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_k = 1'b0; rx_cv_err = 1'b0; rx_disp_err = 1'b0;
        s_rst_n = 1'b0; s_data = 8'h00; s_k = 1'b0; s_cv = 1'b0; s_de = 1'b0;
        test_reset();
        test_clean_stream();
        test_wrap();
        test_async_reset();
        test_loss_of_lock();
        test_sync_fault();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
